// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared definitions for the memory arbiter slice.
//   AW / DW      : word address and data widths used by the arbiter and its ports
//   ST_*         : FSM state encoding (IDLE, BUSY, DONE)
//   GNT_*        : owner codes driven on gnt (none, cpu, sprite, sound)
//   gnt_is_rom() : true for the two read-only ROM ports (sprite and sound)
package mem_arb_pkg;

  localparam int AW = 20;
  localparam int DW = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_CPU  = 2'd1;
  localparam logic [1:0] GNT_SPR  = 2'd2;
  localparam logic [1:0] GNT_SND  = 2'd3;

  function automatic logic gnt_is_rom(input logic [1:0] g);
    return g[1];
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick -- combinational winner selection for mem_arb.
//   cpureq, sprreq, sndreq : pending requests
//   rr_snd                 : round-robin pointer, 1 = sound wins a spr/snd tie
//   starve                 : cpu has used up its consecutive-grant allowance
//   win                    : winning port as a GNT_* code (GNT_NONE if idle)
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       cpureq,
  input  logic       sprreq,
  input  logic       sndreq,
  input  logic       rr_snd,
  input  logic       starve,
  output logic [1:0] win
);

  always_comb begin
    win = GNT_NONE;
    // The cpu has priority, but yields once the starve limit is reached
    // and a ROM port is waiting.
    if (cpureq && !(starve && (sprreq || sndreq))) begin
      win = GNT_CPU;
    end else if (sprreq && sndreq) begin
      win = rr_snd ? GNT_SND : GNT_SPR;
    end else if (sprreq) begin
      win = GNT_SPR;
    end else if (sndreq) begin
      win = GNT_SND;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// mem_arb -- three-port arbiter (cpu, sprite C-ROM, sound V-ROM) in front of
// a single DDR controller port.
//   clk, rst                         : clock, async active-high reset
//   cpureq/cpuaddr/cpuwdata/cpuwr    : cpu request (read or write), cpuack pulse
//   sprreq/spraddr, sprack           : sprite ROM read request, completion pulse
//   sndreq/sndaddr, sndack           : sound ROM read request, completion pulse
//   rdata                            : read data, valid in the cycle of an ack
//   memreq/memaddr/memwdata/memwr    : request to the DDR controller
//   memack/memrdata                  : DDR completion pulse and read data
//   gnt                              : current owner (GNT_* code)
//   state_dbg                        : FSM state (ST_* code) for observation
//
// Handshake: memreq is a level request. Once raised it stays high with
// memaddr/memwdata/memwr frozen until the cycle memack is sampled high;
// memreq drops on the following cycle. memack seen at any other time is
// ignored. Each requester gets exactly one ack pulse per grant and may keep
// its req high to ask again; requests are only sampled in IDLE.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int STARVE = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpureq,
  input  logic [AW-1:0] cpuaddr,
  input  logic [DW-1:0] cpuwdata,
  input  logic          cpuwr,
  output logic          cpuack,
  input  logic          sprreq,
  input  logic [AW-1:0] spraddr,
  output logic          sprack,
  input  logic          sndreq,
  input  logic [AW-1:0] sndaddr,
  output logic          sndack,
  output logic [DW-1:0] rdata,
  output logic          memreq,
  output logic [AW-1:0] memaddr,
  output logic [DW-1:0] memwdata,
  output logic          memwr,
  input  logic          memack,
  input  logic [DW-1:0] memrdata,
  output logic [1:0]    gnt,
  output logic [1:0]    state_dbg
);

  localparam int CW = $clog2(STARVE + 1);

  logic [1:0]    state;
  logic [CW-1:0] starve_cnt;
  logic          rr_snd;
  logic          starve_hit;
  logic          rom_pend;
  logic [1:0]    win;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_wr;

  assign rom_pend   = sprreq | sndreq;
  assign starve_hit = (starve_cnt == CW'(STARVE));
  assign state_dbg  = state;

  mem_arb_pick u_pick (
    .cpureq (cpureq),
    .sprreq (sprreq),
    .sndreq (sndreq),
    .rr_snd (rr_snd),
    .starve (starve_hit),
    .win    (win)
  );

  // Request fields of the winner; ROM ports are read-only, so their write
  // enable and write data are forced to zero.
  always_comb begin
    sel_addr  = cpuaddr;
    sel_wdata = cpuwdata;
    sel_wr    = cpuwr;
    case (win)
      GNT_SPR: begin
        sel_addr  = spraddr;
        sel_wdata = '0;
        sel_wr    = 1'b0;
      end
      GNT_SND: begin
        sel_addr  = sndaddr;
        sel_wdata = '0;
        sel_wr    = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      memreq     <= 1'b0;
      memaddr    <= '0;
      memwdata   <= '0;
      memwr      <= 1'b0;
      cpuack     <= 1'b0;
      sprack     <= 1'b0;
      sndack     <= 1'b0;
      rdata      <= '0;
      gnt        <= GNT_NONE;
      starve_cnt <= '0;
      rr_snd     <= 1'b0;
    end else begin
      cpuack <= 1'b0;
      sprack <= 1'b0;
      sndack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win != GNT_NONE) begin
            memreq   <= 1'b1;
            memaddr  <= sel_addr;
            memwdata <= sel_wdata;
            memwr    <= sel_wr;
            gnt      <= win;
            state    <= ST_BUSY;
            if (gnt_is_rom(win)) begin
              starve_cnt <= '0;
              // Next tie goes to the port that did not just win.
              rr_snd     <= (win == GNT_SPR);
            end else if (rom_pend) begin
              if (!starve_hit) starve_cnt <= starve_cnt + 1'b1;
            end else begin
              starve_cnt <= '0;
            end
          end
        end
        ST_BUSY: begin
          if (memack) begin
            memreq <= 1'b0;
            rdata  <= memwr ? '0 : memrdata;
            cpuack <= (gnt == GNT_CPU);
            sprack <= (gnt == GNT_SPR);
            sndack <= (gnt == GNT_SND);
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          gnt   <= GNT_NONE;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb -- directed bench for mem_arb with an ack scoreboard.
module tb_mem_arb;
  import mem_arb_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpureq = 1'b0;
  logic [19:0]   cpuaddr = '0;
  logic [31:0]   cpuwdata = '0;
  logic          cpuwr = 1'b0;
  logic          cpuack;
  logic          sprreq = 1'b0;
  logic [19:0]   spraddr = '0;
  logic          sprack;
  logic          sndreq = 1'b0;
  logic [19:0]   sndaddr = '0;
  logic          sndack;
  logic [31:0]   rdata;
  logic          memreq;
  logic [19:0]   memaddr;
  logic [31:0]   memwdata;
  logic          memwr;
  logic          memack = 1'b0;
  logic [31:0]   memrdata = '0;
  logic [1:0]    gnt;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  mem_arb #(.STARVE(4)) dut (
    .clk(clk), .rst(rst),
    .cpureq(cpureq), .cpuaddr(cpuaddr), .cpuwdata(cpuwdata), .cpuwr(cpuwr), .cpuack(cpuack),
    .sprreq(sprreq), .spraddr(spraddr), .sprack(sprack),
    .sndreq(sndreq), .sndaddr(sndaddr), .sndack(sndack),
    .rdata(rdata),
    .memreq(memreq), .memaddr(memaddr), .memwdata(memwdata), .memwr(memwr),
    .memack(memack), .memrdata(memrdata),
    .gnt(gnt), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [33:0] exp_q[$];   // {port code, rdata}
  logic [31:0] last_rd = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ack_vec(input logic [1:0] port);
    case (port)
      GNT_CPU: return 3'b100;
      GNT_SPR: return 3'b010;
      GNT_SND: return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Every ack must be expected, unique in its cycle, and carry the right data.
  always @(negedge clk) begin
    if (!rst && (cpuack || sprack || sndack)) begin
      logic [33:0] e;
      check("ack_onehot", 64'($countones({cpuack, sprack, sndack})), 64'd1);
      check("ack_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("ack_port_data", {30'd0, sndack | sprack, sndack | cpuack, rdata}, {30'd0, e});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached with %0d pending acks", exp_q.size());
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Wait for the next grant, check it, hold it for lat cycles, then answer.
  task automatic serve(input logic [1:0] port, input logic [19:0] addr,
                       input logic [31:0] wdata, input logic wr, input int lat,
                       input logic [31:0] rd, input bit scr, output int waited);
    waited = 0;
    do begin
      cyc();
      waited++;
    end while (!memreq && waited < 20);
    check("memreq_seen", 64'(memreq), 64'd1);
    check("gnt", 64'(gnt), 64'(port));
    check("memaddr", 64'(memaddr), 64'(addr));
    check("memwdata", 64'(memwdata), 64'(wdata));
    check("memwr", 64'(memwr), 64'(wr));
    if (scr) begin
      cpuaddr  = 20'($urandom);
      cpuwdata = $urandom;
      cpuwr    = ~cpuwr;
      spraddr  = 20'($urandom);
      sndaddr  = 20'($urandom);
    end
    for (int i = 1; i < lat; i++) begin
      cyc();
      check("busy_hold", 64'({memreq, memwr, memaddr, memwdata}), 64'({1'b1, wr, addr, wdata}));
    end
    memack   = 1'b1;
    memrdata = rd;
    exp_q.push_back({port, wr ? 32'h0 : rd});
    cyc();
    memack   = 1'b0;
    memrdata = $urandom;
    check("ack_lines", 64'({cpuack, sprack, sndack}), 64'(ack_vec(port)));
    check("memreq_drop", 64'(memreq), 64'd0);
    last_rd = wr ? 32'h0 : rd;
  endtask

  function automatic logic [19:0] addr_of(input logic [1:0] port);
    case (port)
      GNT_SPR: return 20'h22222;
      GNT_SND: return 20'h33333;
      default: return 20'h11111;
    endcase
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int waited;
    logic [1:0] order32 [0:14];
    logic [1:0] order33 [0:3];
    order32 = '{GNT_CPU, GNT_CPU, GNT_CPU, GNT_CPU, GNT_SPR,
                GNT_CPU, GNT_CPU, GNT_CPU, GNT_CPU, GNT_SND,
                GNT_CPU, GNT_CPU, GNT_CPU, GNT_CPU, GNT_SPR};
    order33 = '{GNT_SPR, GNT_SND, GNT_SPR, GNT_SND};

    // Reset values
    cyc();
    cyc();
    check("rst_outputs", 64'({memreq, memwr, cpuack, sprack, sndack, gnt, state_dbg}), 64'd0);
    check("rst_addr_data", {12'd0, memaddr, memwdata}, 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    rst = 1'b0;
    cyc();

    // cpu read, memack 3 cycles after memreq, request fields scrambled after grant
    cpureq = 1'b1; cpuaddr = 20'h12345; cpuwr = 1'b0; cpuwdata = 32'h0BAD_0BAD;
    serve(GNT_CPU, 20'h12345, 32'h0BAD_0BAD, 1'b0, 3, 32'hDEADBEEF, 1'b1, waited);
    cpureq = 1'b0;
    check("req_to_memreq", 64'(waited), 64'd1);
    check("rd_cpu_read", 64'(rdata), 64'hDEADBEEF);
    check("gnt_in_done", 64'(gnt), 64'(GNT_CPU));
    cyc();
    check("gnt_back_0", 64'({gnt, state_dbg}), 64'({GNT_NONE, ST_IDLE}));
    cyc();

    // cpu write: data to memory, rdata forced to 0 at the ack
    cpureq = 1'b1; cpuaddr = 20'h00010; cpuwr = 1'b1; cpuwdata = 32'hCAFEF00D;
    serve(GNT_CPU, 20'h00010, 32'hCAFEF00D, 1'b1, 4, 32'h1234_5678, 1'b0, waited);
    cpureq = 1'b0; cpuwr = 1'b0;
    check("rd_cpu_write", 64'(rdata), 64'd0);
    cyc();
    cyc();

    // All three requesting: starve limit lets a ROM port in every 5th grant
    cpuaddr = addr_of(GNT_CPU); spraddr = addr_of(GNT_SPR); sndaddr = addr_of(GNT_SND);
    cpuwdata = 32'h5A5A_0001; cpuwr = 1'b0;
    cpureq = 1'b1; sprreq = 1'b1; sndreq = 1'b1;
    for (int i = 0; i < 15; i++) begin
      serve(order32[i], addr_of(order32[i]),
            (order32[i] == GNT_CPU) ? 32'h5A5A_0001 : 32'h0, 1'b0, 2, $urandom, 1'b0, waited);
      check("starve_latency", 64'(waited), 64'((i == 0) ? 1 : 2));
    end
    cpureq = 1'b0; sprreq = 1'b0; sndreq = 1'b0;
    cyc();
    cyc();

    // Reset during BUSY, then a stray memack just after release
    cpureq = 1'b1; cpuaddr = 20'h0ABCD;
    waited = 0;
    do begin
      cyc();
      waited++;
    end while (!memreq && waited < 20);
    check("rst_test_memreq", 64'(memreq), 64'd1);
    cpureq = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_async", 64'({memreq, gnt, state_dbg}), 64'd0);
    cyc();
    rst = 1'b0;
    cyc();
    memack = 1'b1; memrdata = 32'h7777_7777;
    cyc();
    memack = 1'b0;
    check("rst_stray_ack", 64'({memreq, cpuack, sprack, sndack, state_dbg}), 64'd0);
    check("rst_rdata_clear", 64'(rdata), 64'd0);
    cyc();
    cyc();
    check("rst_idle", 64'({memreq, gnt, state_dbg}), 64'd0);
    cpureq = 1'b1; cpuaddr = 20'h0F00F; cpuwdata = 32'h1;
    serve(GNT_CPU, 20'h0F00F, 32'h1, 1'b0, 2, 32'hA1B2C3D4, 1'b0, waited);
    cpureq = 1'b0;
    check("post_rst_latency", 64'(waited), 64'd1);
    cyc();
    cyc();

    // ROM ports alone: strict alternation starting from spr after reset
    sprreq = 1'b1; sndreq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      serve(order33[i], addr_of(order33[i]), 32'h0, 1'b0, $urandom_range(1, 4), $urandom, 1'b0, waited);
    end
    sprreq = 1'b0; sndreq = 1'b0;
    cyc();
    cyc();

    // Stray memack in IDLE
    memack = 1'b1; memrdata = 32'h5555AAAA;
    cyc();
    memack = 1'b0;
    cyc();
    check("stray_rdata", 64'(rdata), 64'(last_rd));
    check("stray_idle", 64'({memreq, gnt, state_dbg, cpuack, sprack, sndack}), 64'd0);

    cyc();
    cyc();
    check("acks_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter STARVE, default 4: max consecutive cpu grants while spr or snd is pending.
REQ-002 clk  in  1  system clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 cpureq  in  1  cpu request; cpuaddr in 20 word address; cpuwdata in 32 write data; cpuwr in 1 write when high.
REQ-005 cpuack  out  1  one-cycle completion pulse to cpu port.
REQ-006 sprreq  in  1  sprite C-ROM read request; spraddr in 20; sprack out 1 completion pulse.
REQ-007 sndreq  in  1  sound V-ROM read request; sndaddr in 20; sndack out 1 completion pulse.
REQ-008 rdata  out  32  read data, shared by all ports, valid in the cycle of the matching ack.
REQ-009 memreq  out  1  request to DDR controller; memaddr out 20; memwdata out 32; memwr out 1.
REQ-010 memack  in  1  one-cycle DDR completion; memrdata in 32 valid with memack.
REQ-011 gnt  out  2  current owner: 0 none, 1 cpu, 2 spr, 3 snd.

Function
REQ-012 States IDLE, BUSY, DONE; requests are sampled only in IDLE.
REQ-013 IDLE with any req high: select winner, latch its addr/wdata/wr into memaddr/memwdata/memwr, assert memreq and set gnt from the next cycle, go BUSY.
REQ-014 Selection: cpu wins unless the starve counter equals STARVE and spr or snd is pending; otherwise spr/snd contend round-robin.
REQ-015 Round-robin: pointer alternates between spr and snd; the port not granted last wins when both are pending; a lone pending port always wins.
REQ-016 Starve counter: +1 on a cpu grant while spr or snd is high, 0 on any spr/snd grant, 0 on a cpu grant with spr and snd low; saturates at STARVE.
REQ-017 spr and snd: memwr forced 0 and memwdata forced 0 on their grants.
REQ-018 BUSY: memreq, memaddr, memwdata, memwr held stable until memack.
REQ-019 BUSY with memack: next cycle memreq=0, go DONE, rdata<=memrdata (write grants: rdata<=0), owner ack=1 for exactly that cycle.
REQ-020 DONE: unconditionally go IDLE; gnt returns to 0.
REQ-021 A req still high in IDLE after its ack is treated as a new request (back-to-back allowed).
REQ-022 Minimum latency: req high at cycle n -> memreq at n+1; memack at m -> ack at m+1; next memreq no earlier than m+3.
REQ-023 Only one ack output is high in any cycle; no ack is issued for a port that did not win.
REQ-024 memack outside BUSY is ignored.
REQ-025 Requester addr/wdata/wr changes after grant are not propagated.

Reset
REQ-026 rst high: state IDLE, memreq=0, memaddr=0, memwdata=0, memwr=0, all acks 0, rdata=0, gnt=0, starve counter 0, round-robin pointer favouring spr.
REQ-027 rst mid-transaction abandons it: memreq drops asynchronously, no ack is issued, and no memack is consumed after release.

Structure
REQ-028 Shared package holds the state encoding, gnt codes, and the 20/32 address/data width constants used by mem and switch.
REQ-029 One sub-module, mem_arb_pick: combinational winner selection from reqs, pointer and starve flag; the FSM and registers live in mem_arb.

Verification
REQ-030 cpureq alone, addr 0x12345, wr=0; memack 3 cycles after memreq with memrdata 0xDEADBEEF -> memreq 1 cycle after req, cpuack 1 cycle after memack, rdata 0xDEADBEEF, gnt 1 then 0.
REQ-031 cpu write addr 0x00010, wdata 0xCAFEF00D -> memwr=1, memwdata 0xCAFEF00D stable through BUSY; rdata=0 at cpuack.
REQ-032 cpureq, sprreq, sndreq held high, memack 2 cycles after each memreq -> grant order cpu x4, spr, cpu x4, snd, cpu x4, spr (STARVE=4).
REQ-033 sprreq and sndreq held high, cpureq low -> grants alternate spr, snd, spr, snd; no port gets two consecutive grants.
REQ-034 rst asserted in the BUSY cycle, then memack pulsed 1 cycle after release -> memreq low immediately, no ack pulses, state IDLE, next request served normally.
REQ-035 Stray memack in IDLE with no requests -> no ack, rdata unchanged, gnt 0.
